// File: rtl/branch_comp.sv
// Branch comparator: registered branch-taken flag plus the raw eq/lt/ltu flags
// for the RISC-V PC-select and control logic. Single register stage, full throughput.
module branch_comp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] RD1,
  input  logic [WIDTH-1:0] RD2,
  input  logic [2:0]       BrOp,
  input  logic             BrEn,
  output logic             BrRes,
  output logic             BrValid,
  output logic             Eq,
  output logic             Lt,
  output logic             Ltu
);

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_BLT  = 3'b100;
  localparam logic [2:0] OP_BGE  = 3'b101;
  localparam logic [2:0] OP_BLTU = 3'b110;
  localparam logic [2:0] OP_BGEU = 3'b111;

  // Reserved funct3 encodings (010, 011) never report taken.
  function automatic logic sel_cond(input logic [2:0] op, input logic eq,
                                    input logic lt, input logic ltu);
    logic taken;
    taken = 1'b0;
    case (op)
      OP_BEQ:  taken = eq;
      OP_BNE:  taken = !eq;
      OP_BLT:  taken = lt;
      OP_BGE:  taken = !lt;
      OP_BLTU: taken = ltu;
      OP_BGEU: taken = !ltu;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  logic signed [WIDTH-1:0] rd1_s_p0;
  logic signed [WIDTH-1:0] rd2_s_p0;
  logic eq_p0;
  logic lt_p0;
  logic ltu_p0;

  logic br_res_d,   br_res_q;
  logic br_valid_d, br_valid_q;
  logic eq_d,       eq_q;
  logic lt_d,       lt_q;
  logic ltu_d,      ltu_q;

  // Stage p0: combinational compare; both operands signed so lt uses a sign-aware compare.
  always_comb begin
    rd1_s_p0   = $signed(RD1);
    rd2_s_p0   = $signed(RD2);
    eq_p0      = (RD1 == RD2);
    lt_p0      = (rd1_s_p0 < rd2_s_p0);
    ltu_p0     = (RD1 < RD2);
    br_res_d   = BrEn & sel_cond(BrOp, eq_p0, lt_p0, ltu_p0);
    br_valid_d = BrEn;
    eq_d       = eq_p0;
    lt_d       = lt_p0;
    ltu_d      = ltu_p0;
  end

  // Stage p1: output register; reset clears every output, request on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_res_q   <= 1'b0;
      br_valid_q <= 1'b0;
      eq_q       <= 1'b0;
      lt_q       <= 1'b0;
      ltu_q      <= 1'b0;
    end else begin
      br_res_q   <= br_res_d;
      br_valid_q <= br_valid_d;
      eq_q       <= eq_d;
      lt_q       <= lt_d;
      ltu_q      <= ltu_d;
    end
  end

  assign BrRes   = br_res_q;
  assign BrValid = br_valid_q;
  assign Eq      = eq_q;
  assign Lt      = lt_q;
  assign Ltu     = ltu_q;

endmodule

// File: tb/tb_branch_comp.sv
// Self-checking bench for branch_comp: directed test-plan cases followed by
// randomized traffic against an integer-arithmetic reference model.
module tb_branch_comp;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] RD1;
  logic [WIDTH-1:0] RD2;
  logic [2:0]       BrOp;
  logic             BrEn;
  logic             BrRes;
  logic             BrValid;
  logic             Eq;
  logic             Lt;
  logic             Ltu;

  int n_cmp;
  int n_err;

  branch_comp #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .RD1    (RD1),
    .RD2    (RD2),
    .BrOp   (BrOp),
    .BrEn   (BrEn),
    .BrRes  (BrRes),
    .BrValid(BrValid),
    .Eq     (Eq),
    .Lt     (Lt),
    .Ltu    (Ltu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  // Reference: operands as mathematical integers; returns {taken, valid, eq, lt, ltu}.
  function automatic logic [4:0] ref_model(input logic r, input logic [31:0] a,
                                           input logic [31:0] b, input logic [2:0] op,
                                           input logic en);
    longint ua, ub, sa, sb;
    logic e, l, lu, t;
    if (r) return 5'b00000;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= 64'sd2147483648) ? ua - 64'sd4294967296 : ua;
    sb = (ub >= 64'sd2147483648) ? ub - 64'sd4294967296 : ub;
    e  = (ua == ub);
    l  = (sa < sb);
    lu = (ua < ub);
    case (op)
      3'd0: t = e;
      3'd1: t = !e;
      3'd4: t = l;
      3'd5: t = !l;
      3'd6: t = lu;
      3'd7: t = !lu;
      default: t = 1'b0;
    endcase
    return {t & en, en, e, l, lu};
  endfunction

  // Drive one set of inputs, clock one edge, check all outputs #1 after the edge.
  task automatic step(input string tag, input logic r, input logic [31:0] a,
                      input logic [31:0] b, input logic [2:0] op, input logic en);
    logic [4:0] exp;
    rst  = r;
    RD1  = a;
    RD2  = b;
    BrOp = op;
    BrEn = en;
    exp  = ref_model(r, a, b, op, en);
    @(posedge clk);
    #1;
    chk({tag, ".BrRes"},   BrRes,   exp[4]);
    chk({tag, ".BrValid"}, BrValid, exp[3]);
    chk({tag, ".Eq"},      Eq,      exp[2]);
    chk({tag, ".Lt"},      Lt,      exp[1]);
    chk({tag, ".Ltu"},     Ltu,     exp[0]);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0000;
      4: return 32'h0000_0001 << $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a, b;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; RD1 = '0; RD2 = '0; BrOp = '0; BrEn = 1'b0;
    #1;

    step("reset",      1'b1, 32'h1234_5678, 32'h1234_5678, 3'b000, 1'b1);
    step("eq_beq",     1'b0, 32'hFFBB_CCAA, 32'hFFBB_CCAA, 3'b000, 1'b1);
    chk("eq_beq.const", BrRes, 1'b1);
    step("eq_bne",     1'b0, 32'hFFBB_CCAA, 32'hFFBB_CCAA, 3'b001, 1'b1);
    chk("eq_bne.const", BrRes, 1'b0);
    step("ne_beq",     1'b0, 32'hFFBB_CCAA, 32'hFFFF_FFFF, 3'b000, 1'b1);
    chk("ne_beq.lt", Lt, 1'b1);
    chk("ne_beq.ltu", Ltu, 1'b1);
    step("ne_bge",     1'b0, 32'hFFBB_CCAA, 32'hFFFF_FFFF, 3'b101, 1'b1);
    step("ne_bgeu",    1'b0, 32'hFFBB_CCAA, 32'hFFFF_FFFF, 3'b111, 1'b1);
    step("split_blt",  1'b0, 32'h8000_0000, 32'h0000_0001, 3'b100, 1'b1);
    chk("split_blt.const", BrRes, 1'b1);
    chk("split.lt", Lt, 1'b1);
    chk("split.ltu", Ltu, 1'b0);
    step("split_bltu", 1'b0, 32'h8000_0000, 32'h0000_0001, 3'b110, 1'b1);
    chk("split_bltu.const", BrRes, 1'b0);
    step("split_bgeu", 1'b0, 32'h8000_0000, 32'h0000_0001, 3'b111, 1'b1);
    step("b2b_0",      1'b0, 32'hF7A9_9BC4, 32'h0000_0001, 3'b000, 1'b1);
    chk("b2b_0.const", BrRes, 1'b0);
    step("b2b_1",      1'b0, 32'hF7A9_9BC4, 32'hF7A9_9BC4, 3'b000, 1'b1);
    chk("b2b_1.const", BrRes, 1'b1);
    step("gate_off",   1'b0, 32'h1234_5678, 32'h1234_5678, 3'b000, 1'b0);
    chk("gate_off.const", BrValid, 1'b0);
    step("rsv_010",    1'b0, 32'h1234_5678, 32'h1234_5678, 3'b010, 1'b1);
    step("rsv_011",    1'b0, 32'h1234_5678, 32'h1234_5678, 3'b011, 1'b1);

    // Reset mid-operation: establish taken, then reset with a live request.
    step("pre_rst",    1'b0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 3'b000, 1'b1);
    step("rst_edge",   1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 3'b000, 1'b1);
    chk("rst_edge.const", BrRes, 1'b0);
    step("post_rst",   1'b0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 3'b000, 1'b1);
    chk("post_rst.const", BrRes, 1'b1);

    // A reset pulse wholly between edges must not disturb the registered outputs.
    rst = 1'b1;
    #3;
    chk("mid_rst.BrRes", BrRes, 1'b1);
    chk("mid_rst.Eq", Eq, 1'b1);
    rst = 1'b0;
    step("after_mid",  1'b0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 3'b000, 1'b1);

    for (int i = 0; i < 400; i++) begin
      a = pick_operand();
      b = ($urandom_range(0, 3) == 0) ? a : pick_operand();
      step("rand", ($urandom_range(0, 19) == 0), a, b, 3'($urandom_range(0, 7)),
           ($urandom_range(0, 4) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
